addsub_serial: RTL and testbench

Parametrised digit-serial adder/subtractor: adds or subtracts two W-bit operands D bits per clock and reports sum/difference plus carry, signed-overflow and zero flags. It is the multi-cycle, area-reduced generalisation of the team's 4-bit combinational add/sub cell. It uses a ready/start/done handshake so a controller or datapath sequencer can issue one operation at a time.

---
 rtl/addsub_serial_if.sv | 15 +
 rtl/addsub_serial.sv | 91 +++++++++
 tb/tb_addsub_serial.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: start/ready/done handshake, operands and result flags of the serial add/sub unit
interface addsub_serial_if #(parameter int W = 16);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         ready;
  logic         done;
  logic [W-1:0] s;
  logic         c;
  logic         v;
  logic         z;
  modport master (output start, a, b, m, input ready, done, s, c, v, z);
  modport slave  (input start, a, b, m, output ready, done, s, c, v, z);
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial W-bit adder/subtractor, D bits per cycle, with carry/overflow/zero flags
module addsub_serial #(
  parameter int W = 16,
  parameter int D = 4
) (
  input logic clk,
  input logic rst,
  addsub_serial_if.slave io
);
  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, p_q, p_d, s_q, s_d;
  logic         cy_q, cy_d, c_q, c_d, v_q, v_d, z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D:0]   dsum;
  logic         cin_msb;
  logic         last;
  assign dsum    = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + (D+1)'(cy_q);
  // carry into the digit's top bit is recovered from its sum and operand bits
  assign cin_msb = dsum[D-1] ^ a_q[D-1] ^ b_q[D-1];
  assign last    = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    if (state_q == IDLE && io.start) begin
      a_d     = io.a;
      b_d     = io.b ^ {W{io.m}};
      cy_d    = io.m;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> D;
      b_d   = b_q >> D;
      p_d   = (p_q >> D) | (W'(dsum[D-1:0]) << (W - D));
      cy_d  = dsum[D];
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        s_d     = p_d;
        c_d     = dsum[D];
        v_d     = cin_msb ^ dsum[D];
        z_d     = p_d == '0;
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end
  assign io.ready = state_q == IDLE;
  assign io.done  = state_q == DONE;
  assign io.s     = s_q;
  assign io.c     = c_q;
  assign io.v     = v_q;
  assign io.z     = z_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed and swept checks of addsub_serial in three width/digit configurations
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  addsub_serial_if #(.W(16)) io16 ();
  addsub_serial_if #(.W(8))  io8  ();
  addsub_serial_if #(.W(32)) io32 ();
  addsub_serial #(.W(16), .D(4)) u16 (.clk(clk), .rst(rst), .io(io16.slave));
  addsub_serial #(.W(8),  .D(8)) u8  (.clk(clk), .rst(rst), .io(io8.slave));
  addsub_serial #(.W(32), .D(1)) u32 (.clk(clk), .rst(rst), .io(io32.slave));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m, output int lat, output int low);
    io16.a = a; io16.b = b; io16.m = m; io16.start = 1'b1;
    @(posedge clk); #1;
    io16.start = 1'b0;
    lat = 0; low = 0;
    while (!io16.done && lat < 100) begin
      if (!io16.ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    while (!io16.ready && low < 100) begin
      low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic vec16(input string name, input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [15:0] es, input logic ec, input logic ev, input logic ez);
    int lat, low;
    op16(a, b, m, lat, low);
    chk({name, " latency"}, lat, 4);
    chk({name, " s"}, io16.s, es);
    chk({name, " c"}, io16.c, ec);
    chk({name, " v"}, io16.v, ev);
    chk({name, " z"}, io16.z, ez);
  endtask

  task automatic test_reset;
    io16.start = 0; io16.a = 0; io16.b = 0; io16.m = 0;
    io8.start = 0;  io8.a = 0;  io8.b = 0;  io8.m = 0;
    io32.start = 0; io32.a = 0; io32.b = 0; io32.m = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ready", io16.ready, 1);
    chk("reset done", io16.done, 0);
    chk("reset s", io16.s, 0);
    chk("reset c", io16.c, 0);
    chk("reset v", io16.v, 0);
    chk("reset z", io16.z, 0);
  endtask

  task automatic test_add;
    int lat, low;
    op16(16'h1234, 16'h0FFF, 1'b0, lat, low);
    chk("add latency", lat, 4);
    chk("add ready low cycles", low, 5);
    chk("add s", io16.s, 16'h2233);
    chk("add c", io16.c, 0);
    chk("add v", io16.v, 0);
    chk("add z", io16.z, 0);
    vec16("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vec16("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_sub;
    vec16("sub 5-7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    vec16("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    vec16("sub abcd-abcd", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_cur, exp_prev;
    int last_acc = -1;
    int accepts = 0;
    exp_prev = 16'h0000;
    exp_cur  = 16'h0000;
    io16.m = 1'b0;
    io16.start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (io16.done) begin
        chk("b2b result", io16.s, exp_cur);
        exp_prev = exp_cur;
      end else begin
        chk("b2b hold", io16.s, exp_prev);
      end
      io16.a = 16'(cyc * 16'h0101 + 1);
      io16.b = 16'(cyc * 7);
      if (io16.ready) begin
        if (last_acc >= 0) chk("b2b accept spacing", cyc - last_acc, 6);
        last_acc = cyc;
        accepts++;
        exp_cur = io16.a + io16.b;
      end
      @(posedge clk); #1;
    end
    io16.start = 1'b0;
    chk("b2b accept count", accepts, 7);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    int lat, low;
    vec16("pre 1234+1", 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
    io16.a = 16'h1111; io16.b = 16'h2222; io16.m = 1'b0; io16.start = 1'b1;
    @(posedge clk); #1;
    io16.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort done", io16.done, 0);
    chk("abort s", io16.s, 0);
    chk("abort c", io16.c, 0);
    chk("abort v", io16.v, 0);
    chk("abort z", io16.z, 0);
    chk("abort ready", io16.ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort no done", io16.done, 0);
    end
    op16(16'h0001, 16'h0001, 1'b0, lat, low);
    chk("after abort latency", lat, 4);
    chk("after abort s", io16.s, 16'h0002);
  endtask

  task automatic test_sweep_w8;
    logic [7:0] a, b, bb, s;
    logic m, c, v;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom_range(0, 1));
      bb = m ? ~b : b;
      {c, s} = {1'b0, a} + {1'b0, bb} + 9'(m);
      v = (a[7] == bb[7]) && (s[7] != a[7]);
      io8.a = a; io8.b = b; io8.m = m; io8.start = 1'b1;
      @(posedge clk); #1;
      io8.start = 1'b0;
      lat = 0;
      while (!io8.done && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w8 latency", lat, 1);
      chk("w8 s", io8.s, s);
      chk("w8 c", io8.c, c);
      chk("w8 v", io8.v, v);
      chk("w8 z", io8.z, s == 8'h00);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep_w32;
    logic [31:0] a, b, bb, s;
    logic m, c, v;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; m = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; m = 1'b0; end
      if (i == 1) begin a = 32'h8000_0000; b = 32'h0000_0001; m = 1'b1; end
      bb = m ? ~b : b;
      {c, s} = {1'b0, a} + {1'b0, bb} + 33'(m);
      v = (a[31] == bb[31]) && (s[31] != a[31]);
      io32.a = a; io32.b = b; io32.m = m; io32.start = 1'b1;
      @(posedge clk); #1;
      io32.start = 1'b0;
      io32.a = ~a; io32.b = ~b; io32.m = ~m;
      lat = 0;
      while (!io32.done && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w32 latency", lat, 32);
      chk("w32 s", io32.s, s);
      chk("w32 c", io32.c, c);
      chk("w32 v", io32.v, v);
      chk("w32 z", io32.z, s == 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep_w8();
    test_sweep_w32();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
